random_gen: RTL and testbench
=============================

RANDOM_GEN -- requirements
Module: random_gen

Interface
REQ-001 Parameter SEED, default 16'hACE1, LFSR value loaded on reset and substituted for an all-zero seed.
REQ-002 Parameter DIST_BASE, default 8'd13, offset added to draw bits for dist_out.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 seed_load  input  1  load seed into LFSR this cycle.
REQ-006 seed  input  16  seed value used when seed_load=1.
REQ-007 next  input  1  advance LFSR one step this cycle.
REQ-008 rand_out  output  8  current draw = LFSR state[7:0].
REQ-009 rand_bit  output  1  current draw bit = LFSR state[0].
REQ-010 dist_out  output  8  DIST_BASE + state[2:0]; range 13..20 at default.
REQ-011 rand_valid  output  1  one-cycle pulse: a new value is presented.
REQ-012 state_out  output  16  full LFSR state, for debug and verification.

Function
REQ-013 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, maximal period 65535.
REQ-014 Step: fb = s[15]^s[13]^s[12]^s[10]; s <= {s[14:0], fb}.
REQ-015 rand_out, rand_bit, dist_out and state_out are combinational from the state register; zero added latency.
REQ-016 seed_load=1: s <= seed, or SEED when seed==0; next ignored that cycle (load has priority).
REQ-017 next=1 and seed_load=0: exactly one step per cycle; next held high steps every cycle.
REQ-018 Neither asserted: state holds.
REQ-019 rand_valid registered; high for exactly the cycle after any cycle with seed_load=1 or next=1, low otherwise.
REQ-020 State never becomes zero; if all-zero is detected (e.g. upset), the next edge forces SEED regardless of inputs.
REQ-021 dist_out addition is 8-bit unsigned, wraps modulo 256 (no wrap at default base).
REQ-022 Consumers derive narrower fields by masking rand_out (e.g. &2'b11, &3'b111, &4'b1111); all 8 bits are equally valid.

Reset
REQ-023 rst_n low asynchronously forces s=SEED and rand_valid=0, independent of clk.
REQ-024 During reset: rand_out=8'hE1, rand_bit=1, dist_out=8'd14, state_out=16'hACE1.
REQ-025 First step occurs on the first rising edge with rst_n high and next=1; reset release mid-cycle does not step.
REQ-026 Reset asserted mid-sequence discards the current state; no partial step is retained.

Verification
REQ-027 Reset, then one next pulse -> state_out=16'h59C3, rand_out=8'hC3, dist_out=16; rand_valid high one cycle later.
REQ-028 Second next -> state_out=16'hB387, rand_out=8'h87, dist_out=20, rand_bit=1.
REQ-029 seed_load=1, seed=16'h0000 -> state_out=16'hACE1; seed_load with next both high -> only the load is applied.
REQ-030 next held high 65535 cycles from SEED -> state returns to 16'hACE1, never 0, with no earlier repeat of 16'hACE1.
REQ-031 rst_n pulsed low between clock edges after several steps -> state_out=16'hACE1 immediately and rand_valid=0.
REQ-032 next=0, seed_load=0 for 10 cycles -> all outputs constant and rand_valid=0.

Source files
------------

// File: rtl/random_gen.sv
// 16-bit Fibonacci LFSR random source (x^16+x^14+x^13+x^11+1) with byte, bit and
// offset-distribution views of the current state and a registered new-value strobe.
module random_gen #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [7:0]  DIST_BASE = 8'd13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        next,
    output logic [7:0]  rand_out,
    output logic        rand_bit,
    output logic [7:0]  dist_out,
    output logic        rand_valid,
    output logic [15:0] state_out
);

    // A zero SEED parameter would lock the LFSR, so fall back to a known-good value.
    localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    logic [15:0] state;
    logic [15:0] state_nxt;
    logic        feedback;

    assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

    // Zero-state recovery outranks everything; a load outranks a step.
    always_comb begin
        state_nxt = state;
        if (state == 16'h0000) begin
            state_nxt = SEED_SAFE;
        end else if (seed_load) begin
            state_nxt = (seed == 16'h0000) ? SEED_SAFE : seed;
        end else if (next) begin
            state_nxt = {state[14:0], feedback};
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEED_SAFE;
            rand_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            rand_valid <= seed_load | next;
        end
    end

    assign state_out = state;
    assign rand_out  = state[7:0];
    assign rand_bit  = state[0];
    assign dist_out  = DIST_BASE + {5'b00000, state[2:0]};

endmodule

// File: tb/tb_random_gen.sv
// Self-checking bench for random_gen: directed reset/step/load cases, a randomized
// phase against a behavioural LFSR model, and a full-period walk.
module tb_random_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_load;
    logic [15:0] seed;
    logic        next;
    logic [7:0]  rand_out;
    logic        rand_bit;
    logic [7:0]  dist_out;
    logic        rand_valid;
    logic [15:0] state_out;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state;
    int m_valid;

    random_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_load  (seed_load),
        .seed       (seed),
        .next       (next),
        .rand_out   (rand_out),
        .rand_bit   (rand_bit),
        .dist_out   (dist_out),
        .rand_valid (rand_valid),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lfsr_step(input int s);
        int fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s << 1) | fb) & 32'hFFFF;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".state"}, int'(state_out), m_state);
        check({tag, ".rand"},  int'(rand_out),  m_state & 32'hFF);
        check({tag, ".bit"},   int'(rand_bit),  m_state & 1);
        check({tag, ".dist"},  int'(dist_out),  (13 + (m_state & 7)) % 256);
        check({tag, ".valid"}, int'(rand_valid), m_valid);
    endtask

    // Apply inputs for one cycle, advance the model, then observe 1 ns after the edge.
    task automatic cycle(input logic ld, input logic [15:0] sd, input logic nx);
        seed_load = ld;
        seed      = sd;
        next      = nx;
        @(posedge clk);
        #1;
        if (ld) m_state = (sd == 16'h0000) ? 32'hACE1 : int'(sd);
        else if (nx) m_state = lfsr_step(m_state);
        m_valid = (ld || nx) ? 1 : 0;
    endtask

    initial begin
        int zero_hits;
        int early_repeat;
        int model_miss;
        logic [15:0] hold_state;

        seed_load = 1'b0;
        seed      = 16'h0000;
        next      = 1'b1;
        rst_n     = 1'b0;
        m_state   = 32'hACE1;
        m_valid   = 0;

        // Reset values, with next already high while reset is asserted.
        repeat (2) @(posedge clk);
        #1;
        check("reset.state", int'(state_out), 32'hACE1);
        check("reset.rand",  int'(rand_out),  32'hE1);
        check("reset.bit",   int'(rand_bit),  1);
        check("reset.dist",  int'(dist_out),  14);
        check("reset.valid", int'(rand_valid), 0);

        // Release mid-cycle: no step until the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release.nostep", int'(state_out), 32'hACE1);

        cycle(1'b0, 16'h0000, 1'b1);
        check("step1.state", int'(state_out), 32'h59C3);
        check("step1.rand",  int'(rand_out),  32'hC3);
        check("step1.dist",  int'(dist_out),  16);
        check("step1.valid", int'(rand_valid), 1);
        cycle(1'b0, 16'h0000, 1'b1);
        check("step2.state", int'(state_out), 32'hB387);
        check("step2.rand",  int'(rand_out),  32'h87);
        check("step2.dist",  int'(dist_out),  20);
        check("step2.bit",   int'(rand_bit),  1);

        // Zero seed substitutes SEED; load beats next.
        cycle(1'b1, 16'h0000, 1'b0);
        check("load0.state", int'(state_out), 32'hACE1);
        cycle(1'b1, 16'h1234, 1'b1);
        check("loadprio.state", int'(state_out), 32'h1234);
        check_outputs("loadprio");

        // Idle cycles: outputs hold and rand_valid falls after the first idle edge.
        cycle(1'b0, 16'h0000, 1'b0);
        hold_state = state_out;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 16'hFFFF, 1'b0);
            check("idle.state", int'(state_out), int'(hold_state));
            check("idle.valid", int'(rand_valid), 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        ld;
            logic [15:0] sd;
            ld = ($urandom_range(0, 7) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            cycle(ld, sd, 1'($urandom));
            check_outputs("rand");
        end

        // Asynchronous reset between edges after a few steps.
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset.state", int'(state_out), 32'hACE1);
        check("midreset.valid", int'(rand_valid), 0);
        next = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_state = 32'hACE1;
        m_valid = 0;

        // Full period from SEED.
        zero_hits    = 0;
        early_repeat = 0;
        model_miss   = 0;
        seed_load = 1'b0;
        next      = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            @(posedge clk);
            #1;
            m_state = lfsr_step(m_state);
            if (state_out == 16'h0000) zero_hits++;
            if (state_out == 16'hACE1 && i < 65535) early_repeat++;
            if (int'(state_out) != m_state) model_miss++;
        end
        check("period.final", int'(state_out), 32'hACE1);
        check("period.zero", zero_hits, 0);
        check("period.early", early_repeat, 0);
        check("period.model", model_miss, 0);
        next = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
